ped_request_gen: RTL

- Requester end of the light controller's change-request interface.
- Conditions a raw pedestrian push-button (synchronise, debounce, release-arm) and drives the controller's N request input with a fixed-width pulse.
- Watches the controller's J/P/C lights for acknowledgement and drives a "WAIT" lamp while a request is outstanding.
- After each request, enforces a lockout so the controller cannot be spammed. Sits beside the light controller at top level.

---
 rtl/ped_req_pkg.sv | 25 ++
 rtl/ped_req_if.sv | 43 ++++
 rtl/sec_tick_gen.sv | 32 +++
 rtl/ped_request_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ped_req_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ped_req_pkg                                                                |
// | Shared state encoding and width helpers for the pedestrian request block. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ped_req_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    REQ      = 3'd2,
    WAIT_ACK = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  localparam int c_STATS_W = 8;

  // Width needed to hold the values 0..val inclusive.
  function automatic int cnt_w(input int val);
    return $clog2(val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ped_req_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ped_req_if                                                                 |
// | Button/light inputs and request/lamp outputs of ped_request_gen.          |
// | PED_REQ_STATS_EN adds the req_cnt / to_cnt statistics outputs.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ped_req_if;

  logic btn;
  logic J;
  logic P;
  logic C;
  logic N;
  logic wait_lamp;
  logic err;
  logic busy;

`ifdef PED_REQ_STATS_EN
  logic [ped_req_pkg::c_STATS_W-1:0] req_cnt;
  logic [ped_req_pkg::c_STATS_W-1:0] to_cnt;

  modport master (
    input  btn, J, P, C,
    output N, wait_lamp, err, busy, req_cnt, to_cnt
  );
  modport slave (
    output btn, J, P, C,
    input  N, wait_lamp, err, busy, req_cnt, to_cnt
  );
`else
  modport master (
    input  btn, J, P, C,
    output N, wait_lamp, err, busy
  );
  modport slave (
    output btn, J, P, C,
    input  N, wait_lamp, err, busy
  );
`endif

endinterface
`default_nettype wire

// File: rtl/sec_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sec_tick_gen                                                               |
// | Prescaler: one-cycle tick every UCY cycles, restartable via clr.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sec_tick_gen #(
  parameter int UCY = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int             c_W    = $clog2(UCY);
  localparam logic [c_W-1:0] c_LAST = c_W'(UCY - 1);

  logic [c_W-1:0] r_cnt;

  assign tick = (r_cnt == c_LAST) && !clr;

  always_ff @(posedge clk) begin
    if (rst || clr || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ped_request_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ped_request_gen                                                            |
// | Debounced push-button to N request pulse, ack watch, timeout and lockout. |
// | Optional macro PED_REQ_STATS_EN: request / timeout saturating counters.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ped_request_gen
  import ped_req_pkg::*;
#(
  parameter int UCY        = 1000,
  parameter int DB_CYC     = 20,
  parameter int N_CYC      = 2,
  parameter int LOCK_SEC   = 3,
  parameter int ACK_TO_SEC = 20
) (
  input  logic      clk,
  input  logic      rst,
  ped_req_if.master bus
);

  localparam int c_DB_W  = cnt_w(DB_CYC);
  localparam int c_N_W   = cnt_w(N_CYC);
  localparam int c_SEC_W = cnt_w((ACK_TO_SEC > LOCK_SEC) ? ACK_TO_SEC : LOCK_SEC);

  localparam logic [c_DB_W-1:0]  c_DB_ONE  = c_DB_W'(1);
  localparam logic [c_DB_W-1:0]  c_DB_FULL = c_DB_W'(DB_CYC);
  localparam logic [c_N_W-1:0]   c_N_ONE   = c_N_W'(1);
  localparam logic [c_N_W-1:0]   c_N_FULL  = c_N_W'(N_CYC);
  localparam logic [c_SEC_W-1:0] c_TO_LAST = c_SEC_W'(ACK_TO_SEC - 1);
  localparam logic [c_SEC_W-1:0] c_LK_LAST = c_SEC_W'(LOCK_SEC - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_sync1;
  logic                r_btn_s;
  logic                r_armed;
  logic [c_DB_W-1:0]   r_db_cnt;
  logic [c_N_W-1:0]    r_n_cnt;
  logic [c_SEC_W-1:0]  r_sec_cnt;
  logic [2:0]          r_snap;
  logic                r_ack_seen;
  logic                r_n;
  logic                r_wait;
  logic                r_err;
  logic                r_busy;
  logic                w_ack;
  logic                w_accept;
  logic                w_timeout;
  logic                w_tick;
  logic                w_clr;

  assign w_ack = ({bus.J, bus.P, bus.C} != r_snap);

  // Restart the prescaler on the ack/REQ-end paths into WAIT_ACK/LOCKOUT. The
  // timeout path needs no clr: the prescaler wraps to 0 on that tick anyway,
  // and keeping tick out of clr avoids a combinational loop.
  assign w_clr = ((r_state == REQ) && (r_n_cnt == c_N_FULL)) ||
                 ((r_state == WAIT_ACK) && w_ack);

  sec_tick_gen #(
    .UCY (UCY)
  ) u_sec_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_btn_s && r_armed) w_state_next = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (!r_btn_s) begin
          w_state_next = IDLE;
        end else if (r_db_cnt == c_DB_FULL) begin
          w_state_next = REQ;
          w_accept     = 1'b1;
        end
      end
      REQ: begin
        if (r_n_cnt == c_N_FULL) w_state_next = (r_ack_seen || w_ack) ? LOCKOUT : WAIT_ACK;
      end
      WAIT_ACK: begin
        if (w_ack) begin
          w_state_next = LOCKOUT;
        end else if (w_tick && (r_sec_cnt == c_TO_LAST)) begin
          w_state_next = LOCKOUT;
          w_timeout    = 1'b1;
        end
      end
      LOCKOUT: begin
        if (w_tick && (r_sec_cnt == c_LK_LAST)) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sync1    <= 1'b0;
      r_btn_s    <= 1'b0;
      r_armed    <= 1'b1;
      r_db_cnt   <= '0;
      r_n_cnt    <= '0;
      r_sec_cnt  <= '0;
      r_snap     <= '0;
      r_ack_seen <= 1'b0;
      r_n        <= 1'b0;
      r_wait     <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_sync1 <= bus.btn;
      r_btn_s <= r_sync1;
      r_state <= w_state_next;
      r_n     <= (w_state_next == REQ);
      r_wait  <= (w_state_next == REQ) || (w_state_next == WAIT_ACK);
      r_busy  <= (w_state_next != IDLE);
      if (w_timeout) r_err <= 1'b1;
      if (w_accept) begin
        r_armed <= 1'b0;
        r_snap  <= {bus.J, bus.P, bus.C};
      end else if ((r_state == IDLE) && !r_btn_s) begin
        r_armed <= 1'b1;
      end
      // Every counter restarts on state entry, so none can wrap.
      if (w_state_next != r_state) begin
        r_db_cnt   <= (w_state_next == DEBOUNCE) ? c_DB_ONE : '0;
        r_n_cnt    <= (w_state_next == REQ) ? c_N_ONE : '0;
        r_sec_cnt  <= '0;
        r_ack_seen <= 1'b0;
      end else begin
        if (r_state == DEBOUNCE) r_db_cnt <= r_db_cnt + 1'b1;
        if (r_state == REQ) begin
          r_n_cnt <= r_n_cnt + 1'b1;
          if (w_ack) r_ack_seen <= 1'b1;
        end
        if (w_tick && ((r_state == WAIT_ACK) || (r_state == LOCKOUT))) begin
          r_sec_cnt <= r_sec_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.N         = r_n;
  assign bus.wait_lamp = r_wait;
  assign bus.err       = r_err;
  assign bus.busy      = r_busy;

`ifdef PED_REQ_STATS_EN
  logic [c_STATS_W-1:0] r_req_cnt;
  logic [c_STATS_W-1:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      if (w_accept && (r_req_cnt != '1)) r_req_cnt <= r_req_cnt + 1'b1;
      if (w_timeout && (r_to_cnt != '1)) r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign bus.req_cnt = r_req_cnt;
  assign bus.to_cnt  = r_to_cnt;
`endif

endmodule
`default_nettype wire
